// File: rtl/id_ex_reg.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_reg
// Purpose  : Decode-to-execute pipeline register with stall, flush, valid bit
//            and a saturating bubble counter for performance debug.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_reg #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StallE,
    input  logic             FlushE,
    input  logic             ClrCnt,
    input  logic             ValidD,
    input  logic             RegWriteD,
    input  logic [1:0]       ResultSrcD,
    input  logic             MemWriteD,
    input  logic             JumpD,
    input  logic             BranchD,
    input  logic [2:0]       ALUControlD,
    input  logic             ALUSrcD,
    input  logic [XLEN-1:0]  RD1D,
    input  logic [XLEN-1:0]  RD2D,
    input  logic [XLEN-1:0]  PCD,
    input  logic [XLEN-1:0]  PCPlus4D,
    input  logic [XLEN-1:0]  ImmExtD,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       RdD,
    output logic             ValidE,
    output logic             RegWriteE,
    output logic [1:0]       ResultSrcE,
    output logic             MemWriteE,
    output logic             JumpE,
    output logic             BranchE,
    output logic [2:0]       ALUControlE,
    output logic             ALUSrcE,
    output logic [XLEN-1:0]  RD1E,
    output logic [XLEN-1:0]  RD2E,
    output logic [XLEN-1:0]  PCE,
    output logic [XLEN-1:0]  PCPlus4E,
    output logic [XLEN-1:0]  ImmExtE,
    output logic [4:0]       Rs1E,
    output logic [4:0]       Rs2E,
    output logic [4:0]       RdE,
    output logic [CNT_W-1:0] BubbleCnt
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             r_valid;
    logic             r_regwrite;
    logic [1:0]       r_resultsrc;
    logic             r_memwrite;
    logic             r_jump;
    logic             r_branch;
    logic [2:0]       r_aluctrl;
    logic             r_alusrc;
    logic [XLEN-1:0]  r_rd1;
    logic [XLEN-1:0]  r_rd2;
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_pcplus4;
    logic [XLEN-1:0]  r_immext;
    logic [4:0]       r_rs1;
    logic [4:0]       r_rs2;
    logic [4:0]       r_rd;
    logic [CNT_W-1:0] r_bubble_cnt;
    logic             w_bubble;

    // Stalled edges deliver nothing new to execute, so they are not bubbles.
    assign w_bubble = FlushE | (~StallE & ~ValidD);

    always_ff @(posedge clk) begin
        if (!reset || FlushE) begin
            // Zeroed indices make hazard logic see x0, so no false forwarding.
            r_valid     <= 1'b0;
            r_regwrite  <= 1'b0;
            r_resultsrc <= 2'b00;
            r_memwrite  <= 1'b0;
            r_jump      <= 1'b0;
            r_branch    <= 1'b0;
            r_aluctrl   <= 3'b000;
            r_alusrc    <= 1'b0;
            r_rd1       <= '0;
            r_rd2       <= '0;
            r_pc        <= '0;
            r_pcplus4   <= '0;
            r_immext    <= '0;
            r_rs1       <= 5'd0;
            r_rs2       <= 5'd0;
            r_rd        <= 5'd0;
        end else if (!StallE) begin
            r_valid     <= ValidD;
            r_regwrite  <= RegWriteD;
            r_resultsrc <= ResultSrcD;
            r_memwrite  <= MemWriteD;
            r_jump      <= JumpD;
            r_branch    <= BranchD;
            r_aluctrl   <= ALUControlD;
            r_alusrc    <= ALUSrcD;
            r_rd1       <= RD1D;
            r_rd2       <= RD2D;
            r_pc        <= PCD;
            r_pcplus4   <= PCPlus4D;
            r_immext    <= ImmExtD;
            r_rs1       <= Rs1D;
            r_rs2       <= Rs2D;
            r_rd        <= RdD;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || ClrCnt) begin
            r_bubble_cnt <= '0;
        end else if (w_bubble && (r_bubble_cnt != c_cnt_max)) begin
            r_bubble_cnt <= r_bubble_cnt + c_cnt_one;
        end
    end

    assign ValidE      = r_valid;
    assign RegWriteE   = r_regwrite;
    assign ResultSrcE  = r_resultsrc;
    assign MemWriteE   = r_memwrite;
    assign JumpE       = r_jump;
    assign BranchE     = r_branch;
    assign ALUControlE = r_aluctrl;
    assign ALUSrcE     = r_alusrc;
    assign RD1E        = r_rd1;
    assign RD2E        = r_rd2;
    assign PCE         = r_pc;
    assign PCPlus4E    = r_pcplus4;
    assign ImmExtE     = r_immext;
    assign Rs1E        = r_rs1;
    assign Rs2E        = r_rs2;
    assign RdE         = r_rd;
    assign BubbleCnt   = r_bubble_cnt;

endmodule
`default_nettype wire
